// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
// Shared types and arithmetic helpers for the R2SDF FFT pipeline stages.
//
// Contents:
//   DATA_W   - signed width of data and twiddle words
//   TW_FRAC  - fractional bits of a twiddle (1 << TW_FRAC represents 1.0)
//   word_t   - signed DATA_W-bit word
//   cplx_t   - packed complex sample {re, im}
//   cplx_add / cplx_sub            - wrapping complex add / subtract
//   cplx_add_half / cplx_sub_half  - add / subtract then arithmetic >> 1,
//                                    computed one bit wider so nothing wraps
//   cplx_twiddle                   - complex multiply by a twiddle, full
//                                    precision, then truncating shift
// ---------------------------------------------------------------------------
package fft_pkg;

   localparam int DATA_W  = 24;
   localparam int TW_FRAC = 8;

   typedef logic signed [DATA_W-1:0] word_t;

   typedef struct packed {
      word_t re;
      word_t im;
   } cplx_t;

   // Wrapping complex add.
   function automatic cplx_t cplx_add(input cplx_t a, input cplx_t b);
      cplx_t r;
      r.re = a.re + b.re;
      r.im = a.im + b.im;
      return r;
   endfunction

   // Wrapping complex subtract (a - b).
   function automatic cplx_t cplx_sub(input cplx_t a, input cplx_t b);
      cplx_t r;
      r.re = a.re - b.re;
      r.im = a.im - b.im;
      return r;
   endfunction

   // (a + b) / 2 with floor rounding; the extra bit keeps the true sum.
   function automatic cplx_t cplx_add_half(input cplx_t a, input cplx_t b);
      cplx_t r;
      logic signed [DATA_W:0] s_re;
      logic signed [DATA_W:0] s_im;
      s_re = (DATA_W+1)'(a.re) + (DATA_W+1)'(b.re);
      s_im = (DATA_W+1)'(a.im) + (DATA_W+1)'(b.im);
      r.re = word_t'(s_re >>> 1);
      r.im = word_t'(s_im >>> 1);
      return r;
   endfunction

   // (a - b) / 2 with floor rounding.
   function automatic cplx_t cplx_sub_half(input cplx_t a, input cplx_t b);
      cplx_t r;
      logic signed [DATA_W:0] s_re;
      logic signed [DATA_W:0] s_im;
      s_re = (DATA_W+1)'(a.re) - (DATA_W+1)'(b.re);
      s_im = (DATA_W+1)'(a.im) - (DATA_W+1)'(b.im);
      r.re = word_t'(s_re >>> 1);
      r.im = word_t'(s_im >>> 1);
      return r;
   endfunction

   // h * w with the products and their sum held at 2*DATA_W+1 bits, then an
   // arithmetic shift by frac (truncation toward -inf) and the low DATA_W
   // bits kept.
   function automatic cplx_t cplx_twiddle(input cplx_t h, input cplx_t w,
                                          input int frac);
      cplx_t r;
      logic signed [2*DATA_W-1:0] p_rr;
      logic signed [2*DATA_W-1:0] p_ii;
      logic signed [2*DATA_W-1:0] p_ri;
      logic signed [2*DATA_W-1:0] p_ir;
      logic signed [2*DATA_W:0]   acc_re;
      logic signed [2*DATA_W:0]   acc_im;
      p_rr   = (2*DATA_W)'(h.re) * (2*DATA_W)'(w.re);
      p_ii   = (2*DATA_W)'(h.im) * (2*DATA_W)'(w.im);
      p_ri   = (2*DATA_W)'(h.re) * (2*DATA_W)'(w.im);
      p_ir   = (2*DATA_W)'(h.im) * (2*DATA_W)'(w.re);
      acc_re = (2*DATA_W+1)'(p_rr) - (2*DATA_W+1)'(p_ii);
      acc_im = (2*DATA_W+1)'(p_ri) + (2*DATA_W+1)'(p_ir);
      r.re   = word_t'(acc_re >>> frac);
      r.im   = word_t'(acc_im >>> frac);
      return r;
   endfunction

endpackage

// File: rtl/fft_delay_line.sv
// ---------------------------------------------------------------------------
// fft_delay_line
// DEPTH-deep complex shift register used as the R2SDF feedback memory.
// A word pushed on an enabled cycle reaches head_o exactly DEPTH enabled
// cycles later. Storage has no reset: stale contents are harmless because
// the stage ignores the head until a full frame has been pushed.
//
// Ports:
//   clk     in   clock
//   en      in   shift enable (one push per enabled cycle)
//   push_i  in   complex word entering the line
//   head_o  out  oldest complex word (combinational from storage)
// ---------------------------------------------------------------------------
module fft_delay_line
   import fft_pkg::*;
#(
   parameter int DEPTH = 64
) (
   input  logic  clk,
   input  logic  en,
   input  cplx_t push_i,
   output cplx_t head_o
);

   cplx_t mem_q [DEPTH];
   cplx_t mem_d [DEPTH];

   // Tap 0 takes the new word; every other tap takes its younger neighbour.
   assign mem_d[0] = push_i;

   genvar gi;
   generate
      for (gi = 1; gi < DEPTH; gi++) begin : g_tap
         assign mem_d[gi] = mem_q[gi-1];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (en) begin
         mem_q <= mem_d;
      end
   end

   assign head_o = mem_q[DEPTH-1];

endmodule

// File: rtl/fft_r2sdf_stage.sv
// ---------------------------------------------------------------------------
// fft_r2sdf_stage
// Radix-2 single-path delay-feedback butterfly stage for the 128-point FFT.
// One complex sample in and one registered complex sample out per step.
// Phase 0 (cnt MSB = 0): the input is stored in the delay line while the
// head (a difference from the previous frame) is twiddled and emitted.
// Phase 1: head + input is emitted and head - input is stored.
// After the last frame, a drain pass of DELAY steps flushes the stored
// differences with zero input.
//
// Build option: define FFT_STAGE_SCALE_EN to halve butterfly sum and
// difference (arithmetic >> 1) so the stage cannot overflow; without it the
// butterfly wraps at DATA_W bits.
//
// Ports:
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   input sample valid
//   din_r/i    in   input sample, signed DATA_W
//   tw_idx     out  twiddle ROM index, combinational (0 outside phase 0)
//   w_r/w_i    in   twiddle from ROM, same cycle as tw_idx
//   out_valid  out  output valid, registered
//   dout_r/i   out  output sample, registered
//
// DATA_W and TW_FRAC must match the values in fft_pkg, whose cplx_t type
// carries the datapath.
// ---------------------------------------------------------------------------
module fft_r2sdf_stage #(
   parameter int DATA_W  = fft_pkg::DATA_W,
   parameter int TW_FRAC = fft_pkg::TW_FRAC,
   parameter int DELAY   = 64
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   input  logic [DATA_W-1:0]          din_r,
   input  logic [DATA_W-1:0]          din_i,
   output logic [$clog2(DELAY)-1:0]   tw_idx,
   input  logic [DATA_W-1:0]          w_r,
   input  logic [DATA_W-1:0]          w_i,
   output logic                       out_valid,
   output logic [DATA_W-1:0]          dout_r,
   output logic [DATA_W-1:0]          dout_i
);

   import fft_pkg::*;

   localparam int CNT_W = $clog2(2*DELAY);
   localparam int IDX_W = $clog2(DELAY);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2*DELAY-1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DELAY);

   // -----------------------------------------------------------------
   // State
   // -----------------------------------------------------------------
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             primed_q, primed_d;   // a full frame is in the line
   logic             drain_q, drain_d;     // flushing the last differences
   logic             fed_q, fed_d;         // real input arrived during drain
   logic             out_valid_q, out_valid_d;
   cplx_t            dout_q, dout_d;

   // -----------------------------------------------------------------
   // Datapath
   // -----------------------------------------------------------------
   logic  step;
   logic  phase;
   logic  cand_valid;
   logic  fed_now;
   cplx_t x;
   cplx_t w;
   cplx_t h;
   cplx_t push;
   cplx_t cand;
   cplx_t bf_sum;
   cplx_t bf_diff;
   cplx_t twid;

   assign step  = in_valid | drain_q;
   assign phase = cnt_q[CNT_W-1];

   // Twiddle index follows the position inside the first half-frame.
   assign tw_idx = phase ? '0 : cnt_q[IDX_W-1:0];

   always_comb begin
      x = '0;
      if (in_valid) begin
         x.re = din_r;
         x.im = din_i;
      end
      w.re = w_r;
      w.im = w_i;
   end

   fft_delay_line #(
      .DEPTH (DELAY)
   ) u_delay_line (
      .clk    (clk),
      .en     (step),
      .push_i (push),
      .head_o (h)
   );

`ifdef FFT_STAGE_SCALE_EN
   assign bf_sum  = cplx_add_half(h, x);
   assign bf_diff = cplx_sub_half(h, x);
`else
   assign bf_sum  = cplx_add(h, x);
   assign bf_diff = cplx_sub(h, x);
`endif

   assign twid = cplx_twiddle(h, w, TW_FRAC);

   // Phase 0 stores the fresh sample and emits the twiddled head, which is
   // only meaningful once a whole frame has passed through.
   always_comb begin
      push       = x;
      cand       = twid;
      cand_valid = primed_q;
      if (phase) begin
         push       = bf_diff;
         cand       = bf_sum;
         cand_valid = 1'b1;
      end
   end

   // -----------------------------------------------------------------
   // Next-state logic
   // -----------------------------------------------------------------
   assign fed_now = fed_q | in_valid;

   always_comb begin
      cnt_d       = cnt_q;
      primed_d    = primed_q;
      drain_d     = drain_q;
      fed_d       = fed_q;
      out_valid_d = 1'b0;
      dout_d      = dout_q;

      if (step) begin
         cnt_d       = cnt_q + CNT_W'(1);
         out_valid_d = cand_valid;
         if (cand_valid) begin
            dout_d = cand;
         end
         if (cnt_q == CNT_LAST) begin
            primed_d = 1'b1;
         end
         if (drain_q) begin
            fed_d = fed_now;
            if (cnt_d == CNT_HALF) begin
               // Drain is over. If a new frame started meanwhile, its first
               // half is already stored, so keep going from mid-frame.
               // Otherwise the stage goes idle at the top of a frame.
               drain_d  = 1'b0;
               fed_d    = 1'b0;
               primed_d = fed_now;
               if (!fed_now) begin
                  cnt_d = '0;
               end
            end
         end
      end else if ((cnt_q == '0) && primed_q) begin
         // Input paused at a frame boundary with differences still stored.
         drain_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         primed_q    <= 1'b0;
         drain_q     <= 1'b0;
         fed_q       <= 1'b0;
         out_valid_q <= 1'b0;
         dout_q      <= '0;
      end else begin
         cnt_q       <= cnt_d;
         primed_q    <= primed_d;
         drain_q     <= drain_d;
         fed_q       <= fed_d;
         out_valid_q <= out_valid_d;
         dout_q      <= dout_d;
      end
   end

   assign out_valid = out_valid_q;
   assign dout_r    = dout_q.re;
   assign dout_i    = dout_q.im;

endmodule

// File: tb/tb_fft_r2sdf_stage.sv
// ---------------------------------------------------------------------------
// tb_fft_r2sdf_stage
// Directed bench for fft_r2sdf_stage with a cosine/sine twiddle ROM model.
// Frame patterns: 0 = impulse (x[0]=256), 1 = constant 100,
// 2 = step (x[0..63]=256, x[64..127]=0). Expected outputs are closed-form
// per pattern: output j<64 is sum j, output 64+k is twiddled difference k.
// ---------------------------------------------------------------------------
module tb_fft_r2sdf_stage;

   localparam int DATA_W = 24;
   localparam int DELAY  = 64;
   localparam int NFR    = 2*DELAY;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              in_valid = 1'b0;
   logic [DATA_W-1:0] din_r = '0;
   logic [DATA_W-1:0] din_i = '0;
   logic [5:0]        tw_idx;
   logic [DATA_W-1:0] w_r;
   logic [DATA_W-1:0] w_i;
   logic              out_valid;
   logic [DATA_W-1:0] dout_r;
   logic [DATA_W-1:0] dout_i;

   fft_r2sdf_stage #(
      .DATA_W  (DATA_W),
      .TW_FRAC (8),
      .DELAY   (DELAY)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .din_r     (din_r),
      .din_i     (din_i),
      .tw_idx    (tw_idx),
      .w_r       (w_r),
      .w_i       (w_i),
      .out_valid (out_valid),
      .dout_r    (dout_r),
      .dout_i    (dout_i)
   );

   always #5 clk = ~clk;

   // Twiddle ROM: W^k = exp(-j*2*pi*k/128) in Q8.
   int rom_r [DELAY];
   int rom_i [DELAY];
   always_comb begin
      w_r = rom_r[tw_idx][DATA_W-1:0];
      w_i = rom_i[tw_idx][DATA_W-1:0];
   end

   function automatic int rnd(real v);
      return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
   endfunction

   // Output capture.
   int cyc = 0;
   int q_r[$];
   int q_i[$];
   int q_c[$];
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         q_r.push_back(int'($signed(dout_r)));
         q_i.push_back(int'($signed(dout_i)));
         q_c.push_back(cyc);
      end
   end

   int n_chk = 0;
   int n_fail = 0;
   int stall_cyc = -100;

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Halving applied by the butterfly when scaling is built in.
   function automatic int scl(input int v);
`ifdef FFT_STAGE_SCALE_EN
      return v >>> 1;
`else
      return v;
`endif
   endfunction

   function automatic int sample_at(input int pat, input int n);
      case (pat)
         0:       return (n == 0) ? 256 : 0;
         1:       return 100;
         default: return (n < 64) ? 256 : 0;
      endcase
   endfunction

   function automatic void exp_at(input int pat, input int j,
                                  output int er, output int ei);
      int k;
      er = 0;
      ei = 0;
      if (j < DELAY) begin
         case (pat)
            0:       er = (j == 0) ? scl(256) : 0;
            1:       er = scl(200);
            default: er = scl(256);
         endcase
      end else begin
         k = j - DELAY;
         case (pat)
            0: if (k == 0) er = scl(256);
            1: er = 0;
            default: begin
               er = (scl(256) * rom_r[k]) >>> 8;
               ei = (scl(256) * rom_i[k]) >>> 8;
            end
         endcase
      end
   endfunction

   task automatic check_seq(input string name, input int pat, input int base);
      int bad = 0;
      int first = -1;
      int ar = 0, ai = 0, xr = 0, xi = 0;
      int er, ei;
      for (int j = 0; j < NFR; j++) begin
         exp_at(pat, j, er, ei);
         if (base + j >= q_r.size()) begin
            bad++;
            if (first < 0) begin
               first = j; ar = -999999; ai = -999999; xr = er; xi = ei;
            end
         end else if (q_r[base+j] != er || q_i[base+j] != ei) begin
            bad++;
            if (first < 0) begin
               first = j; ar = q_r[base+j]; ai = q_i[base+j]; xr = er; xi = ei;
            end
         end
      end
      n_chk++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL %s: %0d of %0d outputs wrong, first at %0d got (%0d,%0d) expected (%0d,%0d)",
                  name, bad, NFR, first, ar, ai, xr, xi);
      end
   endtask

   task automatic drive(input logic v, input int r, input int i);
      @(posedge clk);
      #1;
      in_valid = v;
      din_r    = r[DATA_W-1:0];
      din_i    = i[DATA_W-1:0];
   endtask

   task automatic idle(input int n);
      for (int c = 0; c < n; c++) drive(1'b0, 0, 0);
   endtask

   task automatic run_frame(input int pat, input int stall_at, input string name);
      for (int n = 0; n < NFR; n++) begin
         if (n == stall_at) begin
            for (int s = 0; s < 5; s++) begin
               drive(1'b0, 0, 0);
               if (s == 0) stall_cyc = cyc;
               if (s == 2) check({name, " tw_idx in stall"}, int'(tw_idx), 0);
            end
         end
         drive(1'b1, sample_at(pat, n), 0);
      end
   endtask

   task automatic apply_reset();
      @(posedge clk);
      #1;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      din_r    = '0;
      din_i    = '0;
      repeat (2) @(posedge clk);
      #1;
      q_r.delete();
      q_i.delete();
      q_c.delete();
      rst_n = 1'b1;
   endtask

   typedef struct {
      string name;
      int    pat;
      int    stall_at;
      int    spot;
      int    spot_r;
      int    spot_i;
   } vec_t;

   vec_t vecs [9];

   initial begin
      int gaps;
      int in_win;

      for (int k = 0; k < DELAY; k++) begin
         rom_r[k] = rnd(256.0 * $cos(2.0 * 3.14159265358979 * k / 128.0));
         rom_i[k] = -rnd(256.0 * $sin(2.0 * 3.14159265358979 * k / 128.0));
      end

      vecs[0] = '{"impulse_sum0",  0, -1, 0,  scl(256), 0};
      vecs[1] = '{"impulse_diff0", 0, -1, 64, scl(256), 0};
      vecs[2] = '{"const_sum",     1, -1, 5,  scl(200), 0};
      vecs[3] = '{"const_diff",    1, -1, 100, 0, 0};
      vecs[4] = '{"twid_sum",      2, -1, 10, scl(256), 0};
`ifdef FFT_STAGE_SCALE_EN
      vecs[5] = '{"twid_k32",      2, -1, 96, 0, -128};
      vecs[6] = '{"twid_k16",      2, -1, 80, 90, -91};
      vecs[7] = '{"twid_stall",    2, 70, 80, 90, -91};
`else
      vecs[5] = '{"twid_k32",      2, -1, 96, 0, -256};
      vecs[6] = '{"twid_k16",      2, -1, 80, 181, -181};
      vecs[7] = '{"twid_stall",    2, 70, 80, 181, -181};
`endif
      vecs[8] = '{"impulse_stall", 0, 70, 0,  scl(256), 0};

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      check("reset out_valid", int'(out_valid), 0);
      check("reset dout_r", int'(dout_r), 0);
      check("reset dout_i", int'(dout_i), 0);
      check("reset tw_idx", int'(tw_idx), 0);
      rst_n = 1'b1;

      // Single frame followed by drain, one table record per run.
      for (int v = 0; v < 9; v++) begin
         apply_reset();
         run_frame(vecs[v].pat, vecs[v].stall_at, vecs[v].name);
         idle(DELAY + 8);
         check({vecs[v].name, " count"}, q_r.size(), NFR);
         check_seq({vecs[v].name, " seq"}, vecs[v].pat, 0);
         check({vecs[v].name, " spot_r"},
               (q_r.size() > vecs[v].spot) ? q_r[vecs[v].spot] : -999999, vecs[v].spot_r);
         check({vecs[v].name, " spot_i"},
               (q_i.size() > vecs[v].spot) ? q_i[vecs[v].spot] : -999999, vecs[v].spot_i);
         if (vecs[v].stall_at >= 0) begin
            in_win = 0;
            foreach (q_c[j]) begin
               if (q_c[j] > stall_cyc && q_c[j] <= stall_cyc + 5) in_win++;
            end
            check({vecs[v].name, " outputs during stall"}, in_win, 0);
         end
      end

      // Three back-to-back frames: step, constant, impulse.
      apply_reset();
      run_frame(2, -1, "b2b");
      run_frame(1, -1, "b2b");
      run_frame(0, -1, "b2b");
      idle(DELAY + 8);
      check("b2b count", q_r.size(), 3*NFR);
      check_seq("b2b frame1", 2, 0);
      check_seq("b2b frame2", 1, NFR);
      check_seq("b2b frame3", 0, 2*NFR);
      gaps = 0;
      if (q_c.size() >= 320) begin
         for (int j = 64; j < 319; j++) begin
            if (q_c[j+1] != q_c[j] + 1) gaps++;
         end
      end else begin
         gaps = -1;
      end
      check("b2b contiguous gaps", gaps, 0);

      // Reset in the middle of a frame (after 90 samples).
      apply_reset();
      for (int n = 0; n < 90; n++) drive(1'b1, sample_at(2, n), 0);
      @(posedge clk);
      #1;
      check("pre-reset out_valid", int'(out_valid), 1);
      rst_n    = 1'b0;
      in_valid = 1'b0;
      #1;
      check("midreset out_valid", int'(out_valid), 0);
      check("midreset dout_r", int'(dout_r), 0);
      check("midreset dout_i", int'(dout_i), 0);
      check("midreset tw_idx", int'(tw_idx), 0);
      repeat (2) @(posedge clk);
      #1;
      q_r.delete();
      q_i.delete();
      q_c.delete();
      rst_n = 1'b1;
      run_frame(1, -1, "postreset");
      idle(DELAY + 8);
      check("postreset count", q_r.size(), NFR);
      check("postreset first", (q_r.size() > 0) ? q_r[0] : -999999, scl(200));
      check_seq("postreset seq", 1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
